wb_flatmem_bridge: RTL
======================

WB_FLATMEM_BRIDGE -- requirements
Module: wb_flatmem_bridge

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, legal 1..15: number of ACCESS cycles per transfer.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports wb_adr_i in 19 (word address, bits 19:1), wb_dat_i in 16, wb_dat_o out 16, wb_sel_i in 2, wb_we_i in 1, wb_stb_i in 1, wb_cyc_i in 1, wb_ack_o out 1: Wishbone classic slave.
REQ-005 SHALL have ports mem_addr out 20 (byte address), mem_wr_data out 16, mem_rd_data in 16, mem_we out 1, mem_byte_m out 1: flat byte memory master, combinational read, writes on rising edge when mem_we=1.
REQ-006 SHALL have port rom_wr_o out 1: sticky protected-write flag (ROM_PROTECT_EN only; tied 0 otherwise).

Function
REQ-007 SHALL implement FSM IDLE -> ACCESS -> ACK -> IDLE.
REQ-008 IDLE: on wb_cyc_i=1 and wb_stb_i=1, SHALL latch adr, sel, we, dat into registers, load wait counter with WAIT_STATES-1, go ACCESS.
REQ-009 ACCESS: SHALL decrement counter each cycle; on counter=0 go ACK.
REQ-010 Lane mapping from latched sel: 11 -> mem_addr={adr,0}, mem_byte_m=0, mem_wr_data=dat; 01 -> mem_addr={adr,0}, mem_byte_m=1, mem_wr_data[7:0]=dat[7:0]; 10 -> mem_addr={adr,1}, mem_byte_m=1, mem_wr_data[7:0]=dat[15:8]; 00 -> no memory access (mem_we never asserted).
REQ-011 mem_addr, mem_byte_m, mem_wr_data SHALL be registered and stable through all ACCESS cycles.
REQ-012 Write: mem_we SHALL be 1 only in the final ACCESS cycle (exactly one cycle per transfer).
REQ-013 Read: wb_dat_o SHALL be captured at the end of the final ACCESS cycle: sel 11 -> mem_rd_data; sel 01 -> {8'h00, mem_rd_data[7:0]}; sel 10 -> {mem_rd_data[7:0], 8'h00}; sel 00 -> 16'h0000. Sign-extension bits from memory SHALL never reach wb_dat_o.
REQ-014 wb_dat_o SHALL hold its value until the next read capture.
REQ-015 ACK: wb_ack_o=1 for exactly one cycle, then IDLE; latency sample-to-ack = WAIT_STATES+1 cycles.
REQ-016 Back-to-back: a request still present in IDLE after ACK SHALL start a new transfer (one idle cycle minimum between acks).
REQ-017 Abort: wb_cyc_i=0 in ACCESS SHALL return to IDLE next cycle, no ack, no mem_we in that or later cycles; wb_dat_o unchanged.
REQ-018 Master changing inputs during ACCESS SHALL have no effect (latched values used).

Reset
REQ-019 rst_n=0 SHALL asynchronously force IDLE, counter 0, wb_ack_o=0, wb_dat_o=0, mem_we=0, mem_byte_m=0, mem_addr=0, mem_wr_data=0, rom_wr_o=0.
REQ-020 Reset mid-ACCESS SHALL cancel transfer; no write, no ack after release.

Configuration
REQ-021 Macro ROM_PROTECT_EN defined: writes with target byte address in 20'hF0000..20'hFFFFF SHALL complete normally on Wishbone (ack at normal latency) but mem_we SHALL stay 0, and rom_wr_o SHALL set to 1 and stay until reset.
REQ-022 Macro ROM_PROTECT_EN undefined: no address check, all writes reach memory, rom_wr_o constant 0.

Verification
REQ-023 WAIT_STATES=1: write adr 0x00080 (byte 0x00100), sel 11, dat 0x1234 -> one mem_we pulse, ack 2 cycles after sample; read back sel 11 -> wb_dat_o=0x1234.
REQ-024 Write sel 10, dat 0xAB00 at byte 0x00100 -> mem byte 0x00101=0xAB, 0x00100 unchanged (0x34); read sel 10 -> wb_dat_o=0xAB00.
REQ-025 Memory byte 0x00200=0x80, read sel 01 -> wb_dat_o=0x0080 (no 0xFF80).
REQ-026 WAIT_STATES=4: read -> ack exactly 5 cycles after sample; cyc dropped in 2nd ACCESS cycle of a write -> no mem_we, no ack.
REQ-027 rst_n low in ACCESS of write -> all outputs 0 immediately, memory unchanged, no ack after release.
REQ-028 ROM_PROTECT_EN: write 0x5555 to byte 0xF0010 -> ack, memory unchanged, rom_wr_o=1 held; undefined -> memory=0x5555, rom_wr_o=0.

Source files
------------

// File: rtl/wb_flatmem_bridge.sv
// wb_flatmem_bridge -- Wishbone classic 16-bit slave onto a flat byte-addressed
// memory. Each transfer spends WAIT_STATES cycles in ACCESS, then acks once.
// Build option: define ROM_PROTECT_EN to suppress memory writes that target
// 20'hF0000..20'hFFFFF (the transfer still acks normally) and raise the sticky
// rom_wr_o flag. Without it every write reaches memory and rom_wr_o is 0.
module wb_flatmem_bridge #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:1] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [19:0] mem_addr,
  output logic [15:0] mem_wr_data,
  input  logic [15:0] mem_rd_data,
  output logic        mem_we,
  output logic        mem_byte_m,
  output logic        rom_wr_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [19:0] addr_q, addr_d;
  logic        byte_m_q, byte_m_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic [15:0] rd_lane;
  logic        final_cycle;
`ifdef ROM_PROTECT_EN
  logic        prot_q, prot_d;
  logic        rom_wr_q, rom_wr_d;
`endif

  assign wb_dat_o    = rd_data_q;
  assign wb_ack_o    = (state_q == S_ACK);
  assign mem_addr    = addr_q;
  assign mem_byte_m  = byte_m_q;
  assign mem_wr_data = wr_data_q;
`ifdef ROM_PROTECT_EN
  assign rom_wr_o    = rom_wr_q;
`else
  assign rom_wr_o    = 1'b0;
`endif

  // Last ACCESS cycle of a transfer the master has not abandoned.
  assign final_cycle = (state_q == S_ACCESS) && wb_cyc_i && (cnt_q == '0);

  // Read lane mapping: byte lanes only ever use the low memory byte, so any
  // sign extension the memory puts on bits 15:8 is discarded.
  always_comb begin
    case (sel_q)
      2'b11:   rd_lane = mem_rd_data;
      2'b01:   rd_lane = {8'h00, mem_rd_data[7:0]};
      2'b10:   rd_lane = {mem_rd_data[7:0], 8'h00};
      default: rd_lane = '0;
    endcase
  end

  // Write strobe: one cycle, gated by cyc so an abort in that cycle writes nothing.
  always_comb begin
    mem_we = final_cycle && we_q && (sel_q != 2'b00);
`ifdef ROM_PROTECT_EN
    if (prot_q) mem_we = 1'b0;
`endif
  end

  // Next-state and register-load logic for the IDLE/ACCESS/ACK sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    we_d      = we_q;
    addr_d    = addr_q;
    byte_m_d  = byte_m_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
`ifdef ROM_PROTECT_EN
    prot_d    = prot_q;
    rom_wr_d  = rom_wr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          sel_d   = wb_sel_i;
          we_d    = wb_we_i;
          cnt_d   = CNT_LOAD;
          state_d = S_ACCESS;
          case (wb_sel_i)
            2'b10: begin
              addr_d    = {wb_adr_i, 1'b1};
              byte_m_d  = 1'b1;
              wr_data_d = {8'h00, wb_dat_i[15:8]};
            end
            2'b01: begin
              addr_d    = {wb_adr_i, 1'b0};
              byte_m_d  = 1'b1;
              wr_data_d = {8'h00, wb_dat_i[7:0]};
            end
            default: begin
              addr_d    = {wb_adr_i, 1'b0};
              byte_m_d  = 1'b0;
              wr_data_d = wb_dat_i;
            end
          endcase
`ifdef ROM_PROTECT_EN
          prot_d = wb_we_i && (wb_sel_i != 2'b00) && (wb_adr_i[19:16] == 4'hF);
`endif
        end
      end
      S_ACCESS: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_ACK;
          if (!we_q) rd_data_d = rd_lane;
`ifdef ROM_PROTECT_EN
          if (prot_q) rom_wr_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      byte_m_q  <= 1'b0;
      wr_data_q <= '0;
      rd_data_q <= '0;
`ifdef ROM_PROTECT_EN
      prot_q    <= 1'b0;
      rom_wr_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      byte_m_q  <= byte_m_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
`ifdef ROM_PROTECT_EN
      prot_q    <= prot_d;
      rom_wr_q  <= rom_wr_d;
`endif
    end
  end

endmodule
